// File: rtl/yolov4_layer_seq.sv
// Layer/tile sequencer for the YOLOv4 accelerator: walks layers and tiles through
// weight-load, ifm-load, compute and store phases via req/done handshakes.
module yolov4_layer_seq #(
    parameter int unsigned LAYER_W = 4,
    parameter int unsigned TILE_W  = 8,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [TILE_W-1:0]  layer_tiles,
    input  logic               wgt_done,
    input  logic               ifm_done,
    input  logic               cmp_done,
    input  logic               st_done,
    output logic               wgt_req,
    output logic               ifm_req,
    output logic               cmp_req,
    output logic               st_req,
    output logic [STATE_W-1:0] state,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [STATE_W-1:0] S_IDLE       = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_LOAD_WGT   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_LOAD_IFM   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_COMPUTE    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_STORE      = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_NEXT_LAYER = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_DONE       = STATE_W'(6);

    logic [STATE_W-1:0] r_state,     w_state_nxt;
    logic [LAYER_W-1:0] r_layer_idx, w_layer_nxt;
    logic [TILE_W-1:0]  r_tile_idx,  w_tile_nxt;
    logic [LAYER_W-1:0] r_nl,        w_nl_nxt;
    logic [TILE_W-1:0]  r_nt,        w_nt_nxt;

    logic r_wgt_req, r_ifm_req, r_cmp_req, r_st_req, r_busy, r_done;
    logic w_wgt_req_nxt, w_ifm_req_nxt, w_cmp_req_nxt, w_st_req_nxt, w_busy_nxt, w_done_nxt;

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_layer_idx <= '0;
            r_tile_idx  <= '0;
            r_nl        <= LAYER_W'(1);
            r_nt        <= TILE_W'(1);
            r_wgt_req   <= 1'b0;
            r_ifm_req   <= 1'b0;
            r_cmp_req   <= 1'b0;
            r_st_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_layer_idx <= w_layer_nxt;
            r_tile_idx  <= w_tile_nxt;
            r_nl        <= w_nl_nxt;
            r_nt        <= w_nt_nxt;
            r_wgt_req   <= w_wgt_req_nxt;
            r_ifm_req   <= w_ifm_req_nxt;
            r_cmp_req   <= w_cmp_req_nxt;
            r_st_req    <= w_st_req_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next state; abort outranks every done strobe
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer_idx;
        w_tile_nxt  = r_tile_idx;
        w_nl_nxt    = r_nl;
        w_nt_nxt    = r_nt;
        if (r_state != S_IDLE && abort) begin
            w_state_nxt = S_IDLE;
            w_layer_nxt = '0;
            w_tile_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_LOAD_WGT;
                        w_layer_nxt = '0;
                        w_tile_nxt  = '0;
                        w_nl_nxt    = (num_layers == '0) ? LAYER_W'(1) : num_layers;
                    end
                end
                S_LOAD_WGT: begin
                    if (wgt_done) begin
                        w_state_nxt = S_LOAD_IFM;
                        w_nt_nxt    = (layer_tiles == '0) ? TILE_W'(1) : layer_tiles;
                    end
                end
                S_LOAD_IFM: begin
                    if (ifm_done) w_state_nxt = S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (cmp_done) w_state_nxt = S_STORE;
                end
                S_STORE: begin
                    if (st_done) begin
                        if (r_tile_idx == r_nt - TILE_W'(1)) begin
                            w_state_nxt = S_NEXT_LAYER;
                        end else begin
                            // Weights stay resident across tiles of a layer
                            w_tile_nxt  = r_tile_idx + TILE_W'(1);
                            w_state_nxt = S_LOAD_IFM;
                        end
                    end
                end
                S_NEXT_LAYER: begin
                    if (r_layer_idx == r_nl - LAYER_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_layer_nxt = r_layer_idx + LAYER_W'(1);
                        w_tile_nxt  = '0;
                        w_state_nxt = S_LOAD_WGT;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode of the next state, registered alongside it
    always_comb begin
        w_wgt_req_nxt = (w_state_nxt == S_LOAD_WGT);
        w_ifm_req_nxt = (w_state_nxt == S_LOAD_IFM);
        w_cmp_req_nxt = (w_state_nxt == S_COMPUTE);
        w_st_req_nxt  = (w_state_nxt == S_STORE);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_DONE);
    end

    assign wgt_req   = r_wgt_req;
    assign ifm_req   = r_ifm_req;
    assign cmp_req   = r_cmp_req;
    assign st_req    = r_st_req;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state     = r_state;
    assign layer_idx = r_layer_idx;
    assign tile_idx  = r_tile_idx;

endmodule

// File: tb/tb_yolov4_layer_seq.sv
// Directed bench for yolov4_layer_seq: engines echo each req back as a done strobe
// one cycle later; expected counts and latencies are hand-derived.
module tb_yolov4_layer_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] num_layers;
    logic [7:0] layer_tiles;
    logic       wgt_done, ifm_done, cmp_done, st_done;
    logic       wgt_req, ifm_req, cmp_req, st_req;
    logic [3:0] state;
    logic [3:0] layer_idx;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int tiles[$];
    int layers[$];

    yolov4_layer_seq #(.LAYER_W(4), .TILE_W(8), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_layers(num_layers), .layer_tiles(layer_tiles),
        .wgt_done(wgt_done), .ifm_done(ifm_done), .cmp_done(cmp_done), .st_done(st_done),
        .wgt_req(wgt_req), .ifm_req(ifm_req), .cmp_req(cmp_req), .st_req(st_req),
        .state(state), .layer_idx(layer_idx), .tile_idx(tile_idx),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strb(input logic w, input logic i, input logic c, input logic s);
        wgt_done = w; ifm_done = i; cmp_done = c; st_done = s;
    endtask

    // Echo reqs back as done strobes until the done pulse; cyc counts cycles from start
    task automatic run_auto(output int cyc, output int nw, output int ni,
                            output int nc, output int ns, output int nd);
        cyc = 1; nw = 0; ni = 0; nc = 0; ns = 0; nd = 0;
        tiles.delete();
        layers.delete();
        for (int n = 0; n < 100; n++) begin
            nw += int'(wgt_req); ni += int'(ifm_req);
            nc += int'(cmp_req); ns += int'(st_req); nd += int'(done);
            if (st_req)  tiles.push_back(int'(tile_idx));
            if (wgt_req) layers.push_back(int'(layer_idx));
            if (done) break;
            set_strb(wgt_req, ifm_req, cmp_req, st_req);
            tick();
            cyc++;
        end
        set_strb(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic advance_to(input int st, input int ly, input int tl, output bit found);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (int'(state) == st && int'(layer_idx) == ly && int'(tile_idx) == tl) begin
                found = 1'b1;
                break;
            end
            set_strb(wgt_req, ifm_req, cmp_req, st_req);
            tick();
        end
        set_strb(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cyc, nw, ni, nc, ns, nd;
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_layers = 4'd0; layer_tiles = 8'd0;
        set_strb(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held with random strobes
        for (int i = 0; i < 3; i++) begin
            set_strb(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk("rst_state", state, 0);
            chk("rst_busy", busy, 0);
            chk("rst_reqs", {wgt_req, ifm_req, cmp_req, st_req}, 0);
            chk("rst_done", done, 0);
        end
        set_strb(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("idle_after_rst", state, 0);
        chk("idle_idx", {layer_idx, tile_idx}, 0);

        // Full run: 2 layers x 3 tiles
        num_layers = 4'd2; layer_tiles = 8'd3;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_state", state, 1);
        chk("start_wgt_req", wgt_req, 1);
        chk("start_busy", busy, 1);
        run_auto(cyc, nw, ni, nc, ns, nd);
        chk("run_latency", cyc, 23);
        chk("run_wgt_cnt", nw, 2);
        chk("run_ifm_cnt", ni, 6);
        chk("run_cmp_cnt", nc, 6);
        chk("run_st_cnt", ns, 6);
        chk("run_done_cnt", nd, 1);
        chk("run_state_done", state, 6);
        for (int i = 0; i < 6; i++)
            chk("run_tile_seq", (tiles.size() > i) ? tiles[i] : -1, i % 3);
        for (int i = 0; i < 2; i++)
            chk("run_layer_seq", (layers.size() > i) ? layers[i] : -1, i);
        tick();
        chk("post_done_pulse", done, 0);
        chk("post_busy", busy, 0);
        chk("post_state", state, 0);
        chk("post_layer_hold", layer_idx, 1);
        chk("post_tile_hold", tile_idx, 2);

        // Zero config behaves as one layer, one tile
        num_layers = 4'd0; layer_tiles = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        run_auto(cyc, nw, ni, nc, ns, nd);
        chk("zero_latency", cyc, 6);
        chk("zero_wgt_cnt", nw, 1);
        chk("zero_st_cnt", ns, 1);
        chk("zero_done_cnt", nd, 1);
        tick();
        chk("zero_final_idx", {layer_idx, tile_idx}, 0);

        // Abort in COMPUTE of layer 1 tile 2, with a coincident cmp_done
        num_layers = 4'd2; layer_tiles = 8'd3;
        start = 1'b1; tick(); start = 1'b0;
        advance_to(3, 1, 2, found);
        chk("abort_reach", found, 1);
        abort = 1'b1; cmp_done = 1'b1;
        tick();
        abort = 1'b0; cmp_done = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_idx", {layer_idx, tile_idx}, 0);
        chk("abort_busy_req", {busy, cmp_req, st_req}, 0);
        nd = int'(done);
        for (int i = 0; i < 3; i++) begin
            tick();
            nd += int'(done);
        end
        chk("abort_no_done", nd, 0);
        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_idx", {layer_idx, tile_idx}, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_wgt", state, 0);

        // Stray cmp_done in LOAD_IFM, start ignored in STORE
        num_layers = 4'd1; layer_tiles = 8'd2;
        start = 1'b1; tick(); start = 1'b0;
        advance_to(2, 0, 0, found);
        chk("stray_reach", found, 1);
        cmp_done = 1'b1; tick(); cmp_done = 1'b0;
        chk("stray_cmp_ignored", state, 2);
        ifm_done = 1'b1; tick(); ifm_done = 1'b0;
        chk("ifm_to_compute", state, 3);
        cmp_done = 1'b1; tick(); cmp_done = 1'b0;
        chk("cmp_to_store", state, 4);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_state", state, 4);
        chk("start_ignored_tile", tile_idx, 0);
        abort = 1'b1; st_done = 1'b1; tick(); abort = 1'b0; st_done = 1'b0;
        chk("abort_vs_st_done", state, 0);
        chk("abort_vs_st_done_pulse", done, 0);

        // Asynchronous reset between edges during LOAD_IFM
        num_layers = 4'd2; layer_tiles = 8'd2;
        start = 1'b1; tick(); start = 1'b0;
        advance_to(2, 0, 0, found);
        chk("arst_reach", found, 1);
        ifm_done = 1'b1; tick(); ifm_done = 1'b0;
        cmp_done = 1'b1; tick(); cmp_done = 1'b0;
        st_done = 1'b1; tick(); st_done = 1'b0;
        chk("arst_tile1", {state, tile_idx}, {4'd2, 8'd1});
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_reqs_busy", {wgt_req, ifm_req, cmp_req, st_req, busy, done}, 0);
        chk("arst_idx", {layer_idx, tile_idx}, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_idle_after", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
